bstep_error_profiler: RTL and testbench

Sequential characterisation harness for the approximate binary-step activation circuits. It sweeps every input code through a combinational Bstep DUT and compares each DUT output with the exact step function. It reports the mismatch count and the first failing code. It sits beside one DUT instance in the library's self-check wrapper and is started from the test controller with a start/done handshake.

---
 rtl/bstep_prof_pkg.sv | 16 +
 rtl/bstep_exact_ref.sv | 13 +
 rtl/bstep_error_profiler.sv | 157 +++++++++++++++
 tb/tb_bstep_error_profiler.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bstep_prof_pkg.sv
// Shared types and the exact binary-step rule used by the Bstep error profilers.
package bstep_prof_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Two's-complement code is non-negative exactly when its sign bit is clear.
  function automatic logic exact_step(input logic [31:0] code, input int width);
    return ~code[width-1];
  endfunction

endpackage

// File: rtl/bstep_exact_ref.sv
// Combinational exact binary-step reference; also usable as a golden DUT.
module bstep_exact_ref
  import bstep_prof_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_code,
  output logic             o_exact
);

  assign o_exact = exact_step(32'(i_code), WIDTH);

endmodule

// File: rtl/bstep_error_profiler.sv
// Sweeps every input code through a combinational Bstep DUT, counting mismatches
// against the exact step function and recording the lowest failing code.
module bstep_error_profiler
  import bstep_prof_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH:0]   err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_in
);

  localparam logic [WIDTH-1:0] LAST_CODE = '1;
  localparam logic [WIDTH-1:0] CODE_ONE  = WIDTH'(1);
  localparam logic [WIDTH:0]   CNT_ONE   = (WIDTH+1)'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_dut_in;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;
  logic [WIDTH:0]   r_err_count;
  logic             r_first_err_valid;
  logic [WIDTH-1:0] r_first_err_in;
  logic             r_cmp_valid;
  logic [WIDTH-1:0] r_cmp_code;
  logic             r_cmp_out;

  logic             w_accept;
  logic             w_capture;
  logic             w_cmp_en;
  logic             w_abort_hit;
  logic             w_exact;

  // The DUT output is captured with its code, so comparison runs one cycle later.
  bstep_exact_ref #(.WIDTH(WIDTH)) u_exact (
    .i_code  (r_cmp_code),
    .o_exact (w_exact)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_cmp_en     = 1'b0;
    w_abort_hit  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = SWEEP;
        end
      end
      SWEEP: begin
        if (abort) begin
          w_abort_hit  = 1'b1;
          w_state_next = DONE;
        end else begin
          w_capture = 1'b1;
          w_cmp_en  = r_cmp_valid;
          if (r_dut_in == LAST_CODE) begin
            w_state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          w_abort_hit  = 1'b1;
        end else begin
          w_cmp_en = r_cmp_valid;
        end
        w_state_next = DONE;
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dut_in          <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_aborted         <= 1'b0;
      r_err_count       <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_in    <= '0;
      r_cmp_valid       <= 1'b0;
      r_cmp_code        <= '0;
      r_cmp_out         <= 1'b0;
    end else begin
      r_done <= (w_state_next == DONE);
      if (w_accept) begin
        r_dut_in          <= '0;
        r_err_count       <= '0;
        r_first_err_valid <= 1'b0;
        r_aborted         <= 1'b0;
        r_busy            <= 1'b1;
        r_cmp_valid       <= 1'b0;
      end
      if (w_capture) begin
        r_cmp_code  <= r_dut_in;
        r_cmp_out   <= dut_out;
        r_cmp_valid <= 1'b1;
        // Hold the last code through DRAIN rather than wrapping to zero.
        if (r_dut_in != LAST_CODE) begin
          r_dut_in <= r_dut_in + CODE_ONE;
        end
      end
      if (w_cmp_en && (r_cmp_out != w_exact)) begin
        r_err_count <= r_err_count + CNT_ONE;
        if (!r_first_err_valid) begin
          r_first_err_valid <= 1'b1;
          r_first_err_in    <= r_cmp_code;
        end
      end
      if (w_abort_hit) begin
        r_aborted <= 1'b1;
      end
      if (w_state_next == DONE) begin
        r_busy      <= 1'b0;
        r_cmp_valid <= 1'b0;
      end
    end
  end

  assign dut_in          = r_dut_in;
  assign busy            = r_busy;
  assign done            = r_done;
  assign aborted         = r_aborted;
  assign err_count       = r_err_count;
  assign first_err_valid = r_first_err_valid;
  assign first_err_in    = r_first_err_in;

endmodule

// File: tb/tb_bstep_error_profiler.sv
// Randomized self-checking bench: stub DUTs selected by mode, results checked
// against a code-by-code model of the sweep built from the timing rules.
module tb_bstep_error_profiler;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] dut_in;
  logic         dut_out;
  logic         busy;
  logic         done;
  logic         aborted;
  logic [W:0]   err_count;
  logic         first_err_valid;
  logic [W-1:0] first_err_in;

  int           mode = 0;
  logic [15:0]  lut = '0;
  logic         w_ref;
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  bstep_error_profiler #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .dut_in          (dut_in),
    .dut_out         (dut_out),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_in    (first_err_in)
  );

  // Stub DUTs: 0 golden, 1 ~In[0], 2 tied 0, 3 tied 1, 4 random truth table.
  bstep_exact_ref #(.WIDTH(W)) u_golden (.i_code(dut_in), .o_exact(w_ref));

  always_comb begin
    dut_out = w_ref;
    case (mode)
      1:       dut_out = ~dut_in[0];
      2:       dut_out = 1'b0;
      3:       dut_out = 1'b1;
      4:       dut_out = lut[dut_in];
      default: dut_out = w_ref;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic stub_model(input int md, input int k);
    int  sval;
    logic ex;
    sval = (k >= 8) ? k - 16 : k;
    ex   = (sval >= 0);
    case (md)
      1:       return ~k[0];
      2:       return 1'b0;
      3:       return 1'b1;
      4:       return lut[k];
      default: return ex;
    endcase
  endfunction

  // ab: cycle (1-based after start) in which abort is held high, 0 = none.
  // rs: cycle in which a stray start is pulsed, 0 = none.
  task automatic run_sweep(input int md, input int ab, input int rs);
    int   n, done_cyc, last, cnt, first, exp_done, sval;
    logic fv, ex, has_ab;
    mode = md;
    if (md == 4) lut = 16'($urandom);
    has_ab   = (ab >= 1 && ab <= 17);
    last     = has_ab ? ab - 3 : 15;
    exp_done = has_ab ? ab + 1 : 18;
    cnt = 0; fv = 1'b0; first = 0;
    for (int k = 0; k <= last; k++) begin
      sval = (k >= 8) ? k - 16 : k;
      ex   = (sval >= 0);
      if (stub_model(md, k) != ex) begin
        cnt++;
        if (!fv) begin
          fv    = 1'b1;
          first = k;
        end
      end
    end

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 1;
    done_cyc = 0;
    while (n <= 40 && done_cyc == 0) begin
      abort = (n == ab);
      start = (n == rs);
      if (done === 1'b1) begin
        done_cyc = n;
      end else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    abort = 1'b0;
    start = 1'b0;
    chk("done_cycle", done_cyc, exp_done);
    chk("busy_at_done", busy, 0);
    chk("aborted", aborted, has_ab);
    chk("err_count", err_count, cnt);
    chk("first_err_valid", first_err_valid, fv);
    if (fv) chk("first_err_in", first_err_in, first);
    @(posedge clk);
    #1;
    chk("done_single_pulse", done, 0);
    chk("err_count_held", err_count, cnt);
    $display("sweep mode=%0d abort_cyc=%0d restart_cyc=%0d done_cyc=%0d err=%0d first=%0d valid=%0d aborted=%0d",
             md, ab, rs, done_cyc, err_count, first_err_in, first_err_valid, aborted);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dut_in"}, dut_in, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_first_err_valid"}, first_err_valid, 0);
    chk({tag, "_first_err_in"}, first_err_in, 0);
  endtask

  initial begin
    #2;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(1, 0, 0);
    run_sweep(0, 0, 0);
    run_sweep(2, 0, 0);
    run_sweep(3, 0, 0);
    run_sweep(1, 5, 0);
    run_sweep(1, 0, 5);
    run_sweep(1, 17, 0);
    run_sweep(3, 1, 0);

    // Reset asserted in cycle 7 of a sweep.
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("midreset_no_done", done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset asserted in cycle 7 of a sweep, outputs cleared");

    for (int r = 0; r < 20; r++) begin
      int md, ab;
      md = $urandom_range(0, 4);
      ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 17) : 0;
      run_sweep(md, ab, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
